// File: rtl/freq_meas_pkg.sv
// Shared definitions for the frequency-measurement sequencer and its BCD converter.
package freq_meas_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ARM     = 3'd1,
        GATE    = 3'd2,
        CONVERT = 3'd3,
        DONE    = 3'd4
    } measState_t;

    localparam int CNT_MAX    = 9999;
    localparam int CNT_W      = 14;
    localparam int BCD_W      = 16;
    localparam int BCD_DIGITS = BCD_W / 4;

    // Add-3 correction applied to every BCD digit that is 5 or more, ahead of the next shift.
    function automatic logic [BCD_W-1:0] dabbleAdjust(input logic [BCD_W-1:0] bcd);
        logic [BCD_W-1:0] adj;
        adj = bcd;
        for (int d = 0; d < BCD_DIGITS; d++) begin
            if (bcd[4*d +: 4] >= 4'd5) begin
                adj[4*d +: 4] = bcd[4*d +: 4] + 4'd3;
            end
        end
        return adj;
    endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble converter: one shift per clock, oReady rises BIN_W cycles after iLoad.
module bin2bcd_seq
    import freq_meas_pkg::*;
#(
    parameter int BIN_W = CNT_W
) (
    input  logic             iClk,
    input  logic             iRst_n,
    input  logic             iLoad,
    input  logic [BIN_W-1:0] iBin,
    output logic [BCD_W-1:0] oBcd,
    output logic             oReady
);

    localparam int STEP_W = $clog2(BIN_W + 1);

    logic [BIN_W-1:0]  binShift;
    logic [BCD_W-1:0]  bcdShift;
    logic [BCD_W-1:0]  bcdAdjusted;
    logic [STEP_W-1:0] stepsLeft;

    assign bcdAdjusted = dabbleAdjust(bcdShift);
    assign oBcd        = bcdShift;

    // The BCD field starts empty, so the first iteration needs no correction and is folded into the load.
    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            binShift  <= '0;
            bcdShift  <= '0;
            stepsLeft <= '0;
            oReady    <= 1'b0;
        end else if (iLoad) begin
            {bcdShift, binShift} <= {{BCD_W{1'b0}}, iBin} << 1;
            stepsLeft            <= STEP_W'(BIN_W - 1);
            oReady               <= 1'b0;
        end else if (stepsLeft != '0) begin
            {bcdShift, binShift} <= {bcdAdjusted, binShift} << 1;
            stepsLeft            <= stepsLeft - STEP_W'(1);
            oReady               <= (stepsLeft == STEP_W'(1));
        end
    end

endmodule

// File: rtl/freq_meas_ctrl.sv
// Frequency-measurement sequencer: synchronizes the input, counts rising edges over a fixed gate,
// converts the count to BCD and publishes it with a one-cycle done pulse.
module freq_meas_ctrl #(
    parameter int GATE_CYCLES = 50000000,
    parameter int CNT_MAX     = freq_meas_pkg::CNT_MAX,
    parameter int CNT_W       = freq_meas_pkg::CNT_W
) (
    input  logic                            iClk,
    input  logic                            iRst_n,
    input  logic                            iSignal,
    input  logic                            iStart,
    input  logic                            iContinuous,
    input  logic                            iAbort,
    output logic                            oBusy,
    output logic                            oDone,
    output logic [CNT_W-1:0]                oCount,
    output logic [freq_meas_pkg::BCD_W-1:0] oBcd,
    output logic                            oOverflow
);

    import freq_meas_pkg::*;

    localparam int TIMER_W = $clog2(GATE_CYCLES);

    measState_t       state, stateNext;
    logic             syncMeta, syncStable, syncDelay, edgePulse;
    logic [TIMER_W-1:0] gateTimer;
    logic             gateLast;
    logic [CNT_W-1:0] edgeCount, edgeCountNext;
    logic             overflow, overflowNext;
    logic             convLoad, convReady;
    logic [BCD_W-1:0] convBcd;

    assign edgePulse = syncStable & ~syncDelay;
    assign gateLast  = (gateTimer == TIMER_W'(GATE_CYCLES - 1));
    // The converter is fed the post-update count so an edge in the final gate cycle is included.
    assign convLoad  = (state == GATE) && gateLast;
    assign oBusy     = (state != IDLE);
    assign oDone     = (state == DONE);

    always_comb begin
        edgeCountNext = edgeCount;
        overflowNext  = overflow;
        if (state == GATE && edgePulse) begin
            if (edgeCount >= CNT_W'(CNT_MAX)) begin
                overflowNext = 1'b1;
            end else begin
                edgeCountNext = edgeCount + CNT_W'(1);
            end
        end
    end

    always_comb begin
        stateNext = state;
        if (iAbort) begin
            stateNext = IDLE;
        end else begin
            case (state)
                IDLE:    if (iStart) stateNext = ARM;
                ARM:     stateNext = GATE;
                GATE:    if (gateLast) stateNext = CONVERT;
                CONVERT: if (convReady) stateNext = DONE;
                DONE:    stateNext = iContinuous ? ARM : IDLE;
                default: stateNext = IDLE;
            endcase
        end
    end

    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            syncMeta   <= 1'b0;
            syncStable <= 1'b0;
            syncDelay  <= 1'b0;
            gateTimer  <= '0;
            edgeCount  <= '0;
            overflow   <= 1'b0;
            oCount     <= '0;
            oBcd       <= '0;
            oOverflow  <= 1'b0;
        end else begin
            syncMeta   <= iSignal;
            syncStable <= syncMeta;
            syncDelay  <= syncStable;
            case (state)
                ARM: begin
                    gateTimer <= '0;
                    edgeCount <= '0;
                    overflow  <= 1'b0;
                end
                GATE: begin
                    gateTimer <= gateTimer + TIMER_W'(1);
                    edgeCount <= edgeCountNext;
                    overflow  <= overflowNext;
                end
                default: ;
            endcase
            // Publishing on the CONVERT->DONE edge makes the new result visible alongside oDone.
            if (state == CONVERT && convReady && !iAbort) begin
                oCount    <= edgeCount;
                oBcd      <= convBcd;
                oOverflow <= overflow;
            end
        end
    end

    bin2bcd_seq #(
        .BIN_W (CNT_W)
    ) uConv (
        .iClk   (iClk),
        .iRst_n (iRst_n),
        .iLoad  (convLoad),
        .iBin   (edgeCountNext),
        .oBcd   (convBcd),
        .oReady (convReady)
    );

endmodule

// File: tb/tb_freq_meas_ctrl.sv
// Directed bench for freq_meas_ctrl: a table of single-shot measurements plus hand-written
// sequences for saturation, continuous mode, abort and asynchronous reset.
module tb_freq_meas_ctrl;

    localparam int GATE     = 100;
    localparam int SAT_GATE = 25000;
    localparam int DONE_AT  = GATE + 16;
    localparam int NVEC     = 10;

    typedef struct {
        int          period;
        int          firstRise;
        logic        preLevel;
        int          expCount;
        logic [15:0] expBcd;
        logic        expOvf;
    } vec_t;

    logic        iClk = 1'b0;
    logic        iRst_n, iSignal, iStart, iContinuous, iAbort;
    logic        oBusy, oDone, oOverflow;
    logic [13:0] oCount;
    logic [15:0] oBcd;

    logic        satSignal, satStart, satContinuous, satAbort;
    logic        satBusy, satDone, satOverflow;
    logic [13:0] satCount;
    logic [15:0] satBcd;

    int          checkCount = 0;
    int          missCount  = 0;
    int          lastCount;
    logic [15:0] lastBcd;
    logic        lastOvf;
    vec_t        vecs[NVEC];

    always #5 iClk = ~iClk;

    freq_meas_ctrl #(.GATE_CYCLES(GATE)) dut (
        .iClk(iClk), .iRst_n(iRst_n), .iSignal(iSignal), .iStart(iStart),
        .iContinuous(iContinuous), .iAbort(iAbort), .oBusy(oBusy), .oDone(oDone),
        .oCount(oCount), .oBcd(oBcd), .oOverflow(oOverflow)
    );

    freq_meas_ctrl #(.GATE_CYCLES(SAT_GATE)) satDut (
        .iClk(iClk), .iRst_n(iRst_n), .iSignal(satSignal), .iStart(satStart),
        .iContinuous(satContinuous), .iAbort(satAbort), .oBusy(satBusy), .oDone(satDone),
        .oCount(satCount), .oBcd(satBcd), .oOverflow(satOverflow)
    );

    function automatic logic waveAt(input int period, input int firstRise, input logic preLevel, input int k);
        if (period == 0 || k < firstRise) return preLevel;
        return ((k - firstRise) % period) < (period / 2);
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual !== expected) begin
            missCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Cycle k counts negedges after iStart is driven; the start is sampled on the posedge before k=1.
    task automatic applyStimulus(input vec_t v, input int idx);
        int   doneAt;
        int   doneHits;
        logic busyGap;
        doneAt   = 0;
        doneHits = 0;
        busyGap  = 1'b0;
        iSignal  = v.preLevel;
        repeat (10) @(negedge iClk);
        iStart  = 1'b1;
        iSignal = waveAt(v.period, v.firstRise, v.preLevel, 0);
        for (int k = 1; k <= DONE_AT + 4; k++) begin
            @(negedge iClk);
            iStart  = 1'b0;
            iSignal = waveAt(v.period, v.firstRise, v.preLevel, k);
            if (k < DONE_AT && !oBusy) busyGap = 1'b1;
            if (oDone) begin
                doneHits++;
                if (doneAt == 0) doneAt = k;
            end
            if (k == DONE_AT - 1) checkOutput($sformatf("v%0d held count", idx), oCount, lastCount);
            if (k == DONE_AT) begin
                checkOutput($sformatf("v%0d count", idx), oCount, v.expCount);
                checkOutput($sformatf("v%0d bcd", idx), oBcd, v.expBcd);
                checkOutput($sformatf("v%0d overflow", idx), oOverflow, v.expOvf);
                lastCount = v.expCount;
                lastBcd   = v.expBcd;
                lastOvf   = v.expOvf;
            end
            if (k == DONE_AT + 1) checkOutput($sformatf("v%0d idle", idx), oBusy, 0);
        end
        checkOutput($sformatf("v%0d done cycle", idx), doneAt, DONE_AT);
        checkOutput($sformatf("v%0d done pulses", idx), doneHits, 1);
        checkOutput($sformatf("v%0d busy gap", idx), busyGap, 0);
        iSignal = 1'b0;
        repeat (5) @(negedge iClk);
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int   satAt, satHits, doneNum, abortDone;
        logic busyGap;

        vecs[0] = '{10,  5,   1'b0, 10, 16'h0010, 1'b0};
        vecs[1] = '{7,   1,   1'b0, 15, 16'h0015, 1'b0};
        vecs[2] = '{4,   1,   1'b0, 25, 16'h0025, 1'b0};
        vecs[3] = '{3,   1,   1'b0, 33, 16'h0033, 1'b0};
        vecs[4] = '{2,   1,   1'b0, 50, 16'h0050, 1'b0};
        vecs[5] = '{0,   0,   1'b0, 0,  16'h0000, 1'b0};
        vecs[6] = '{0,   0,   1'b1, 0,  16'h0000, 1'b0};
        vecs[7] = '{200, 0,   1'b0, 1,  16'h0001, 1'b0};
        vecs[8] = '{200, 99,  1'b0, 1,  16'h0001, 1'b0};
        vecs[9] = '{200, 100, 1'b0, 0,  16'h0000, 1'b0};

        iRst_n = 1'b0; iSignal = 1'b0; iStart = 1'b0; iContinuous = 1'b0; iAbort = 1'b0;
        satSignal = 1'b0; satStart = 1'b0; satContinuous = 1'b0; satAbort = 1'b0;
        lastCount = 0; lastBcd = 16'h0; lastOvf = 1'b0;
        #12;
        checkOutput("reset busy", oBusy, 0);
        checkOutput("reset done", oDone, 0);
        checkOutput("reset count", oCount, 0);
        checkOutput("reset bcd", oBcd, 0);
        checkOutput("reset overflow", oOverflow, 0);
        @(negedge iClk);
        iRst_n = 1'b1;
        repeat (3) @(negedge iClk);

        for (int i = 0; i < NVEC; i++) applyStimulus(vecs[i], i);

        // Saturation: 12500 edges in a 25000-cycle gate must clamp at 9999.
        $display("[TB] saturation run");
        satAt = 0; satHits = 0;
        satStart  = 1'b1;
        satSignal = waveAt(2, 1, 1'b0, 0);
        for (int k = 1; k <= SAT_GATE + 20; k++) begin
            @(negedge iClk);
            satStart  = 1'b0;
            satSignal = waveAt(2, 1, 1'b0, k);
            if (satDone) begin
                satHits++;
                if (satAt == 0) satAt = k;
                checkOutput("sat count", satCount, 9999);
                checkOutput("sat bcd", satBcd, 16'h9999);
                checkOutput("sat overflow", satOverflow, 1);
            end
        end
        checkOutput("sat done cycle", satAt, SAT_GATE + 16);
        checkOutput("sat done pulses", satHits, 1);
        satSignal = 1'b0;

        // Continuous mode: three back-to-back results, continuous dropped during the third gate.
        $display("[TB] continuous run");
        doneNum = 0; busyGap = 1'b0;
        iContinuous = 1'b1;
        repeat (5) @(negedge iClk);
        iStart  = 1'b1;
        iSignal = waveAt(20, 5, 1'b0, 0);
        for (int k = 1; k <= 3 * DONE_AT + 12; k++) begin
            @(negedge iClk);
            iStart  = 1'b0;
            iSignal = waveAt(20, 5, 1'b0, k);
            if (k == 300) iContinuous = 1'b0;
            if (k <= 3 * DONE_AT && !oBusy) busyGap = 1'b1;
            if (oDone) begin
                doneNum++;
                checkOutput($sformatf("cont done%0d cycle", doneNum), k, doneNum * DONE_AT);
                checkOutput($sformatf("cont done%0d count", doneNum), oCount, 5);
                checkOutput($sformatf("cont done%0d bcd", doneNum), oBcd, 16'h0005);
            end
            if (k == 3 * DONE_AT + 1) checkOutput("cont idle after stop", oBusy, 0);
        end
        checkOutput("cont done total", doneNum, 3);
        checkOutput("cont busy gap", busyGap, 0);
        lastCount = 5; lastBcd = 16'h0005; lastOvf = 1'b0;
        iSignal = 1'b0;

        // Abort with a simultaneous start in gate cycle 50, after a result of 10 is on the outputs.
        applyStimulus(vecs[0], 100);
        $display("[TB] abort run");
        abortDone = 0;
        iStart  = 1'b1;
        iSignal = waveAt(10, 5, 1'b0, 0);
        for (int k = 1; k <= 180; k++) begin
            @(negedge iClk);
            iStart  = 1'b0;
            iSignal = waveAt(10, 5, 1'b0, k);
            if (k == 51) begin
                checkOutput("abort busy before", oBusy, 1);
                iStart = 1'b1;
                iAbort = 1'b1;
            end
            if (k == 52) begin
                checkOutput("abort busy after", oBusy, 0);
                iAbort = 1'b0;
            end
            if (oDone) abortDone++;
        end
        checkOutput("abort done pulses", abortDone, 0);
        checkOutput("abort count held", oCount, 10);
        checkOutput("abort bcd held", oBcd, 16'h0010);
        iSignal = 1'b0;
        repeat (5) @(negedge iClk);

        // Asynchronous reset in the middle of CONVERT.
        $display("[TB] reset-in-convert run");
        iStart  = 1'b1;
        iSignal = waveAt(10, 5, 1'b0, 0);
        for (int k = 1; k <= 110; k++) begin
            @(negedge iClk);
            iStart  = 1'b0;
            iSignal = waveAt(10, 5, 1'b0, k);
        end
        checkOutput("convert busy", oBusy, 1);
        #2 iRst_n = 1'b0;
        #1;
        checkOutput("async rst busy", oBusy, 0);
        checkOutput("async rst done", oDone, 0);
        checkOutput("async rst count", oCount, 0);
        checkOutput("async rst bcd", oBcd, 0);
        checkOutput("async rst overflow", oOverflow, 0);
        iSignal = 1'b0;
        @(negedge iClk);
        iRst_n = 1'b1;
        lastCount = 0; lastBcd = 16'h0; lastOvf = 1'b0;
        repeat (3) @(negedge iClk);
        applyStimulus(vecs[0], 200);

        $display("== %0d vectors applied, %0d miscompares ==", checkCount, missCount);
        $finish;
    end

endmodule
